modbus_tx_frame_builder: RTL and testbench
==========================================

MODBUS_TX_FRAME_BUILDER -- requirements
Module: modbus_tx_frame_builder

Interface
REQ-001 SHALL have parameter MAX_QTY, default 8'd125: the largest register count allowed in a 03/04 response.
REQ-002 SHALL have port clk_in, input, 1: the single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port dev_addr, input, 8: slave address placed in byte 0 of every frame.
REQ-005 SHALL have port handler_done, input, 1: one-cycle pulse that starts a response.
REQ-006 SHALL have ports func_code (input, 8), addr (input, 16), data (input, 16): the request fields.
REQ-007 SHALL have ports exception (input, 8) and tx_quantity (input, 8): the handler result.
REQ-008 SHALL have ports dpram_ren (output, 1), dpram_raddr (output, 8) and dpram_rdata (input, 16): the response register buffer.
REQ-009 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1): the byte stream to the UART transmitter.
REQ-010 SHALL have ports tx_done (output, 1): one-cycle end-of-frame pulse; and busy (output, 1): high while a frame is in progress.

Function
REQ-011 SHALL sample all request inputs on a handler_done pulse seen in IDLE, and ignore handler_done while busy.
REQ-012 SHALL use these states: IDLE, HDR_ADDR, HDR_FUNC, BODY, RD_REQ, RD_WAIT, DATA_HI, DATA_LO, CRC_LO, CRC_HI, DONE.
REQ-013 SHALL select the frame from the latched values:
- exception!=0: exception frame.
- exception==0, func 03/04, qty>MAX_QTY: exception frame with code 03.
- exception==0, func 03/04: read frame.
- exception==0, func 06: echo frame.
- exception==0, any other func: exception frame with code 01.
REQ-014 Exception frame SHALL be: dev_addr, func_code|0x80, code, CRC_lo, CRC_hi.
REQ-015 Read frame SHALL be: dev_addr, func_code, byte count (2*qty, 8 bits), then words dpram[0..qty-1] high byte first, CRC_lo, CRC_hi.
REQ-016 A read frame with qty==0 SHALL be dev_addr, func_code, 0x00, CRC_lo, CRC_hi.
REQ-017 Echo frame SHALL be: dev_addr, 0x06, addr_hi, addr_lo, data_hi, data_lo, CRC_lo, CRC_hi.
REQ-018 SHALL transfer a byte only on a cycle with tx_valid&&tx_ready.
REQ-019 While tx_valid&&!tx_ready, tx_data SHALL stay stable and tx_valid SHALL stay high.
REQ-020 SHALL assert tx_valid with byte 0 in the cycle after the accepted handler_done.
REQ-021 SHALL read the DPRAM as follows:
- RD_REQ pulses dpram_ren for one cycle with dpram_raddr=word index.
- dpram_rdata is captured one cycle later (RD_WAIT).
- tx_valid is low during RD_REQ and RD_WAIT.
- Each word is read exactly once.
REQ-022 SHALL compute CRC as Modbus CRC-16: init 0xFFFF, reflected polynomial 0xA001.
REQ-023 SHALL update the CRC with a one-cycle, full-byte unrolled step on each accepted byte except the two CRC bytes.
REQ-024 SHALL keep the CRC at 16 bits and reinitialise it on every frame start.
REQ-025 SHALL pulse tx_done for one cycle in DONE, the cycle after CRC_hi is accepted, then return to IDLE.
REQ-026 busy SHALL be high from the cycle after the accepted handler_done through DONE inclusive.
REQ-027 A handler_done arriving in the DONE cycle SHALL be ignored; one arriving on the following cycle (IDLE) SHALL be accepted.
REQ-028 SHALL keep the DPRAM word index in 8 bits; it SHALL never exceed qty-1 and SHALL never wrap.

Reset
REQ-029 On rst_in high at a clock edge, the block SHALL go to IDLE with: tx_valid=0, tx_data=0x00, dpram_ren=0, dpram_raddr=0, tx_done=0, busy=0, CRC=0xFFFF, latched fields=0.
REQ-030 Reset mid-frame SHALL abort without a tx_done pulse; the next handler_done after reset SHALL start a fresh frame.

Verification
REQ-031 dev 0x01, func 0x03, exception 0x02 -> bytes 01 83 02 C0 F1, then one tx_done pulse.
REQ-032 dev 0x01, func 0x06, addr 0x0001, data 0x0003, exception 0 -> bytes 01 06 00 01 00 03 98 0B.
REQ-033 func 0x04, qty 2, dpram[0]=0x1234, dpram[1]=0xABCD -> bytes 01 04 04 12 34 AB CD + CRC matching the model; exactly 2 dpram_ren pulses, at addresses 0 and 1.
REQ-034 func 0x03, qty 126 -> exception frame 01 83 03 + model CRC; no dpram_ren pulse.
REQ-035 tx_ready low for 5 cycles while byte 3 is offered -> tx_data stable, no duplicated or dropped byte, CRC unchanged.
REQ-036 rst_in asserted during DATA_LO of the REQ-033 stimulus -> tx_valid=0 and busy=0 the next cycle, no tx_done; a following handler_done produces a complete, correct frame.

Source files
------------

// File: rtl/modbus_tx_frame_builder.sv
// Modbus RTU response framer: builds exception, read (03/04) and echo (06) frames
// from a handler result, streams them as bytes over a valid/ready link and appends CRC-16.
module modbus_tx_frame_builder #(
  parameter logic [7:0] MAX_QTY = 8'd125
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  dev_addr,
  input  logic        handler_done,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic [7:0]  exception,
  input  logic [7:0]  tx_quantity,
  output logic        dpram_ren,
  output logic [7:0]  dpram_raddr,
  input  logic [15:0] dpram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_done,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, HDR_ADDR, HDR_FUNC, BODY, RD_REQ, RD_WAIT,
    DATA_HI, DATA_LO, CRC_LO, CRC_HI, DONE
  } state_t;

  typedef enum logic [1:0] {K_EXC, K_READ, K_ECHO} kind_t;

  // One full byte of reflected CRC-16 (poly 0xA001) in a single cycle.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  state_t      state;
  kind_t       kind_l, kind_in;
  logic [7:0]  func_l, code_l, qty_l, code_in, word_lo, widx;
  logic [15:0] addr_l, data_l, crc, crc_next;
  logic [1:0]  bidx;
  logic        accept;

  assign accept   = tx_valid && tx_ready;
  assign crc_next = crc16_step(crc, tx_data);

  always_comb begin
    kind_in = K_EXC;
    code_in = exception;
    if (exception != 8'h00) begin
      kind_in = K_EXC;
    end else if (func_code == 8'h03 || func_code == 8'h04) begin
      if (tx_quantity > MAX_QTY) code_in = 8'h03;
      else                       kind_in = K_READ;
    end else if (func_code == 8'h06) begin
      kind_in = K_ECHO;
    end else begin
      code_in = 8'h01;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      dpram_ren   <= 1'b0;
      dpram_raddr <= 8'h00;
      tx_done     <= 1'b0;
      busy        <= 1'b0;
      crc         <= 16'hFFFF;
      kind_l      <= K_EXC;
      func_l      <= 8'h00;
      code_l      <= 8'h00;
      qty_l       <= 8'h00;
      addr_l      <= 16'h0000;
      data_l      <= 16'h0000;
      word_lo     <= 8'h00;
      widx        <= 8'h00;
      bidx        <= 2'd0;
    end else begin
      tx_done   <= 1'b0;
      dpram_ren <= 1'b0;
      case (state)
        IDLE: if (handler_done) begin
          kind_l   <= kind_in;
          code_l   <= code_in;
          func_l   <= func_code;
          qty_l    <= tx_quantity;
          addr_l   <= addr;
          data_l   <= data;
          crc      <= 16'hFFFF;
          widx     <= 8'h00;
          bidx     <= 2'd0;
          tx_data  <= dev_addr;
          tx_valid <= 1'b1;
          busy     <= 1'b1;
          state    <= HDR_ADDR;
        end
        HDR_ADDR: if (accept) begin
          crc     <= crc_next;
          tx_data <= (kind_l == K_EXC) ? (func_l | 8'h80) : func_l;
          state   <= HDR_FUNC;
        end
        HDR_FUNC: if (accept) begin
          crc   <= crc_next;
          state <= BODY;
          case (kind_l)
            K_READ:  tx_data <= {qty_l[6:0], 1'b0};
            K_ECHO:  tx_data <= addr_l[15:8];
            default: tx_data <= code_l;
          endcase
        end
        // Single-byte body for exceptions/byte count; four bytes for echo.
        BODY: if (accept) begin
          crc <= crc_next;
          if (kind_l == K_READ && qty_l != 8'h00) begin
            tx_valid    <= 1'b0;
            dpram_ren   <= 1'b1;
            dpram_raddr <= widx;
            state       <= RD_REQ;
          end else if (kind_l == K_ECHO && bidx != 2'd3) begin
            bidx <= bidx + 2'd1;
            case (bidx)
              2'd0:    tx_data <= addr_l[7:0];
              2'd1:    tx_data <= data_l[15:8];
              default: tx_data <= data_l[7:0];
            endcase
          end else begin
            tx_data <= crc_next[7:0];
            state   <= CRC_LO;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          word_lo  <= dpram_rdata[7:0];
          tx_data  <= dpram_rdata[15:8];
          tx_valid <= 1'b1;
          state    <= DATA_HI;
        end
        DATA_HI: if (accept) begin
          crc     <= crc_next;
          tx_data <= word_lo;
          state   <= DATA_LO;
        end
        DATA_LO: if (accept) begin
          crc <= crc_next;
          if (widx == qty_l - 8'd1) begin
            tx_data <= crc_next[7:0];
            state   <= CRC_LO;
          end else begin
            widx        <= widx + 8'd1;
            dpram_raddr <= widx + 8'd1;
            dpram_ren   <= 1'b1;
            tx_valid    <= 1'b0;
            state       <= RD_REQ;
          end
        end
        CRC_LO: if (accept) begin
          tx_data <= crc[15:8];
          state   <= CRC_HI;
        end
        CRC_HI: if (accept) begin
          tx_valid <= 1'b0;
          tx_done  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_tx_frame_builder.sv
// Directed bench for modbus_tx_frame_builder with a byte scoreboard and DPRAM model.
module tb_modbus_tx_frame_builder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  dev_addr, func_code, exception, tx_quantity;
  logic        handler_done;
  logic [15:0] addr, data;
  logic        dpram_ren;
  logic [7:0]  dpram_raddr;
  logic [15:0] dpram_rdata = 16'h0000;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_done, busy;

  modbus_tx_frame_builder dut (
    .clk_in(clk_in), .rst_in(rst_in), .dev_addr(dev_addr), .handler_done(handler_done),
    .func_code(func_code), .addr(addr), .data(data), .exception(exception),
    .tx_quantity(tx_quantity), .dpram_ren(dpram_ren), .dpram_raddr(dpram_raddr),
    .dpram_rdata(dpram_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  logic [15:0] mem [256];
  always @(posedge clk_in) if (dpram_ren) dpram_rdata <= mem[dpram_raddr];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] fb [$];
  logic [7:0] ren_log [$];
  int frame_bytes = 0;
  int done_count = 0;
  int done_before = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: bytes in fb, then CRC computed bit-serially, all pushed to exp_q.
  task automatic model(input logic [7:0] dv, fc, input logic [15:0] a, d,
                       input logic [7:0] ex, q);
    logic [15:0] c;
    fb.delete();
    fb.push_back(dv);
    if (ex != 0) begin
      fb.push_back(fc | 8'h80); fb.push_back(ex);
    end else if (fc == 8'h03 || fc == 8'h04) begin
      if (q > 8'd125) begin
        fb.push_back(fc | 8'h80); fb.push_back(8'h03);
      end else begin
        fb.push_back(fc); fb.push_back(8'(2 * q));
        for (int i = 0; i < q; i++) begin
          fb.push_back(mem[i][15:8]); fb.push_back(mem[i][7:0]);
        end
      end
    end else if (fc == 8'h06) begin
      fb.push_back(fc); fb.push_back(a[15:8]); fb.push_back(a[7:0]);
      fb.push_back(d[15:8]); fb.push_back(d[7:0]);
    end else begin
      fb.push_back(fc | 8'h80); fb.push_back(8'h01);
    end
    c = 16'hFFFF;
    foreach (fb[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ fb[i][k]) c = (c >> 1) ^ 16'hA001;
        else                 c = c >> 1;
      end
    end
    fb.push_back(c[7:0]);
    fb.push_back(c[15:8]);
    foreach (fb[i]) exp_q.push_back(fb[i]);
  endtask

  task automatic set_fields(input logic [7:0] dv, fc, input logic [15:0] a, d,
                            input logic [7:0] ex, q);
    dev_addr = dv; func_code = fc; addr = a; data = d; exception = ex; tx_quantity = q;
  endtask

  task automatic start_raw(input string tag, input logic [7:0] dv, fc,
                           input logic [15:0] a, d, input logic [7:0] ex, q);
    set_fields(dv, fc, a, d, ex, q);
    frame_bytes = 0;
    ren_log.delete();
    done_before = done_count;
    handler_done = 1'b1;
    @(posedge clk_in); #1;
    handler_done = 1'b0;
    chk({tag, "_first_valid"}, {31'd0, tx_valid}, 32'd1);
    chk({tag, "_first_byte"}, {24'd0, tx_data}, {24'd0, dv});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic start(input string tag, input logic [7:0] dv, fc,
                       input logic [15:0] a, d, input logic [7:0] ex, q);
    model(dv, fc, a, d, ex, q);
    start_raw(tag, dv, fc, a, d, ex, q);
  endtask

  task automatic finish(input string tag, input int ren_exp);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_in); #1;
      if (done_count != done_before) break;
    end
    chk({tag, "_done_pulses"}, done_count, done_before + 1);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ren_count"}, ren_log.size(), ren_exp);
  endtask

  // Output monitor: scoreboard pop, stall stability, read-port checks, done counting.
  initial begin
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", {31'd0, tx_valid}, 32'd1);
          chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        if (tx_valid && tx_ready) begin
          frame_bytes++;
          if (exp_q.size() == 0) chk("extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
          end
        end
        if (dpram_ren) begin
          ren_log.push_back(dpram_raddr);
          chk("ren_valid_low", {31'd0, tx_valid}, 32'd0);
        end
        if (tx_done) done_count++;
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin
    rst_in = 1'b1; handler_done = 1'b0; tx_ready = 1'b1;
    set_fields(8'h00, 8'h00, 16'h0000, 16'h0000, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0] ^ 8'h5A, ~i[7:0]};
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_ren", {31'd0, dpram_ren}, 32'd0);
    chk("rst_raddr", {24'd0, dpram_raddr}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Exception from handler, literal reference bytes.
    exp_q.push_back(8'h01); exp_q.push_back(8'h83); exp_q.push_back(8'h02);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hF1);
    start_raw("exc02", 8'h01, 8'h03, 16'h0000, 16'h0000, 8'h02, 8'h00);
    finish("exc02", 0);

    // Echo frame, literal reference bytes.
    exp_q.push_back(8'h01); exp_q.push_back(8'h06); exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    exp_q.push_back(8'h98); exp_q.push_back(8'h0B);
    start_raw("echo", 8'h01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00);
    finish("echo", 0);

    start("read2", 8'h01, 8'h04, 16'h0000, 16'h0000, 8'h00, 8'd2);
    finish("read2", 2);
    if (ren_log.size() == 2) begin
      chk("read2_addr0", {24'd0, ren_log[0]}, 32'd0);
      chk("read2_addr1", {24'd0, ren_log[1]}, 32'd1);
    end

    start("qty126", 8'h01, 8'h03, 16'h0000, 16'h0000, 8'h00, 8'd126);
    finish("qty126", 0);
    start("qty125", 8'h11, 8'h03, 16'h0000, 16'h0000, 8'h00, 8'd125);
    finish("qty125", 125);
    if (ren_log.size() == 125) chk("qty125_last_addr", {24'd0, ren_log[124]}, 32'd124);
    start("qty0", 8'h22, 8'h03, 16'h0000, 16'h0000, 8'h00, 8'd0);
    finish("qty0", 0);
    start("badfunc", 8'h33, 8'h10, 16'h0000, 16'h0000, 8'h00, 8'd4);
    finish("badfunc", 0);

    // Stall while byte 3 is offered; a handler_done during the frame is ignored.
    start("stall", 8'h44, 8'h06, 16'hBEEF, 16'h1357, 8'h00, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (frame_bytes == 3) break;
      @(posedge clk_in); #1;
    end
    chk("stall_reach", frame_bytes, 3);
    tx_ready = 1'b0;
    set_fields(8'h55, 8'h05, 16'h0000, 16'h0000, 8'h04, 8'h00);
    handler_done = 1'b1;
    @(posedge clk_in); #1;
    handler_done = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("stall_held_count", frame_bytes, 3);
    tx_ready = 1'b1;
    finish("stall", 0);

    // handler_done in DONE is ignored, the one in the following IDLE cycle starts a frame.
    start("b2b_a", 8'h01, 8'h03, 16'h0000, 16'h0000, 8'h02, 8'h00);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in); #1;
      if (tx_done) break;
    end
    chk("b2b_done_seen", {31'd0, tx_done}, 32'd1);
    set_fields(8'h66, 8'h06, 16'h0102, 16'h0304, 8'h00, 8'h00);
    handler_done = 1'b1;
    @(posedge clk_in); #1;
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_valid", {31'd0, tx_valid}, 32'd0);
    model(8'h66, 8'h06, 16'h0102, 16'h0304, 8'h00, 8'h00);
    start_raw("b2b_b", 8'h66, 8'h06, 16'h0102, 16'h0304, 8'h00, 8'h00);
    finish("b2b_b", 0);

    // Reset during DATA_LO of the first word aborts without tx_done.
    start("rstmid", 8'h01, 8'h04, 16'h0000, 16'h0000, 8'h00, 8'd2);
    for (int i = 0; i < 100; i++) begin
      if (frame_bytes == 4) break;
      @(posedge clk_in); #1;
    end
    chk("rstmid_reach", frame_bytes, 4);
    chk("rstmid_byte", {24'd0, tx_data}, 32'h34);
    tx_ready = 1'b0;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rstmid_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    rst_in = 1'b0;
    tx_ready = 1'b1;
    exp_q.delete();
    repeat (4) @(posedge clk_in);
    #1;
    chk("rstmid_no_done", done_count, done_before);
    start("after_rst", 8'h01, 8'h04, 16'h0000, 16'h0000, 8'h00, 8'd2);
    finish("after_rst", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
